// File: rtl/sram_bank_if.sv
// Request/response channel bundle for sram_bank: valid/ready request with
// byte enables, valid/ready response with read data and range error.
interface sram_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_bank.sv
// Single-port SRAM bank: DEPTH x DATA_W words, one access in flight.
// Each access walks IDLE -> WL (decode/range check) -> PULSE (array access)
// -> RESP (hold response until consumed). Storage is not reset.
module sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_bank_if.slave  bus
);
  localparam int NB = DATA_W / 8;
  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, WL, PULSE, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       be_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rsp_err_q;
  logic                req_ready;
  logic                rsp_valid;

  logic [DATA_W-1:0]   mem [DEPTH];

  // State register; async reset drops any access in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = WL;
      end
      WL:    state_d = PULSE;
      PULSE: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, range decode and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          be_q    <= bus.req_be;
        end
        WL: err_q <= ({1'b0, addr_q} >= DEPTH_W);
        PULSE: begin
          rdata_q   <= (!we_q && !err_q) ? mem[addr_q] : '0;
          rsp_err_q <= err_q;
        end
        default: ;
      endcase
    end
  end

  // Array write at the edge leaving PULSE; state is reset-forced out of
  // PULSE, so a reset there suppresses the commit.
  always_ff @(posedge clk) begin
    if (state_q == PULSE && we_q && !err_q) begin
      for (int k = 0; k < NB; k++)
        if (be_q[k]) mem[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port SRAM bank: the generalised successor to the fixed 32-bit single-word cell row. It holds DEPTH words of DATA_W bits and exposes a valid/ready request channel and a valid/ready response channel. Each access runs an internal word-line / access-pulse sequence with per-byte write enables and address-range checking. It sits between the core's load/store unit and the cell array, as the unit of data memory.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 64: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): request address width.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  bank accepts a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte write enables; bit k covers data bits [8k+7:8k].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  address out of range (req_addr >= DEPTH).

## Operation
- Storage is a DEPTH x DATA_W array. rst_n does not affect it. Contents before the first write to a word are undefined.
- The FSM has four states: IDLE, WL, PULSE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/addr/wdata/be and go to WL.
- WL (word-line setup):
  - Decode the latched address and set the internal err flag = (addr >= DEPTH).
  - Go to PULSE.
- PULSE (access pulse), effective at the edge leaving PULSE:
  - Write with err=0: word[addr] byte k <= wdata byte k for every set be[k]; other bytes unchanged. be = 0 leaves the word unchanged.
  - Read with err=0: rsp_rdata <= word[addr].
  - Any access with err=1: no storage change, rsp_rdata <= 0.
  - Write (any err): rsp_rdata <= 0.
  - rsp_err <= err. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable.
  - On rsp_ready, go to IDLE. Otherwise stay, with no timeout.
- req_ready = 0 in WL, PULSE and RESP. Requests presented in those states are not accepted and must be held by the requester.
- Only one access is in flight. There is no overlap of RESP with a new accept.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, all latched request fields 0.
- Accept at edge E0 (req_valid & req_ready). WL occupies cycle E0–E1. PULSE occupies E1–E2. Storage write and read capture both happen at E2.
- rsp_valid is high in the cycle after E2, i.e. two edges after accept.
- RESP handshake at edge E3 (rsp_ready=1) returns to IDLE. req_ready is high in the following cycle.
- Minimum request spacing is 4 cycles: accept, WL, PULSE, RESP with rsp_ready tied high.
- Read after write to the same address returns the new data; the write commits before the read's PULSE.
- Reset mid-operation:
  - rst_n low in WL or PULSE: state forced to IDLE, and the pending write does not commit.
  - A write already committed at E2 persists.
  - Any response in progress is dropped: rsp_valid goes to 0 immediately.
- rsp_ready held low in RESP keeps rsp_valid, rsp_rdata and rsp_err constant indefinitely.
- A maximum-address access (req_addr = DEPTH-1) is legal. With DEPTH=48, ADDR_W=6, addresses 48..63 are errors.

## Test plan
- Reset, then idle: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Write addr 5, wdata 0xDEADBEEF, be 0xF; then read addr 5 -> rsp_rdata 0xDEADBEEF and rsp_err 0. rsp_valid rises 2 edges after each accept.
- Byte mask: write 0x11223344 (be 0xF) to addr 7, then 0xAABBCCDD with be 0x5, then read addr 7 -> 0x11BB33DD.
- DEPTH=48: write addr 50 -> rsp_err 1 with no storage change. Read addr 50 -> rsp_err 1, rsp_rdata 0. Read addr 47 returns its previously written value.
- Backpressure: hold rsp_ready low 10 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready 0 while req_valid is held high. Release -> the next request is accepted the cycle after.
- Assert rst_n low during PULSE of a write of 0x0 to addr 3 (previously 0xCAFEF00D) -> outputs return to reset values immediately, and a later read of addr 3 gives 0xCAFEF00D.
